// File: rtl/serial_mux_tx_pkg.sv
// Shared types and constants for the serial_mux_tx transmit path.
// Parity bit is generated only when SERIAL_MUX_TX_PARITY_EN is defined.
package serial_mux_pkg;

    localparam int NUM_CH = 4;
    localparam int PORT_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_PAR
    } state_t;

endpackage

// File: rtl/serial_mux_tx_rr_arbiter4.sv
// Four-way round-robin arbiter, purely combinational.
// Search starts one past the previous winner.
module rr_arbiter4
    import serial_mux_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [PORT_W-1:0] last_grant,
    input  logic              en,
    output logic [NUM_CH-1:0] gnt_onehot,
    output logic [PORT_W-1:0] gnt_idx,
    output logic              any_gnt
);

    always_comb begin
        logic [PORT_W-1:0] v_c;
        v_c        = '0;
        gnt_onehot = '0;
        gnt_idx    = '0;
        any_gnt    = 1'b0;
        if (en) begin
            for (int k = 1; k <= NUM_CH; k++) begin
                v_c = last_grant + PORT_W'(k);
                if (!any_gnt && req[v_c]) begin
                    any_gnt        = 1'b1;
                    gnt_idx        = v_c;
                    gnt_onehot[v_c] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/serial_mux_tx.sv
// Four-channel round-robin serializer, LSB first, one word per frame.
// Define SERIAL_MUX_TX_PARITY_EN to append an even-parity bit to each frame.
module serial_mux_tx
    import serial_mux_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_valid,
    output logic [NUM_CH-1:0] ch_ready,
    input  logic [DATA_W-1:0] ch_data0,
    input  logic [DATA_W-1:0] ch_data1,
    input  logic [DATA_W-1:0] ch_data2,
    input  logic [DATA_W-1:0] ch_data3,
    output logic              ser_out,
    output logic              ser_valid,
    output logic [PORT_W-1:0] port_num,
    output logic              busy
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_t              r_state;
    logic [DATA_W-1:0]   r_shreg;
    logic [CNT_W-1:0]    r_cnt;
    logic [PORT_W-1:0]   r_last;
    logic [PORT_W-1:0]   r_port;
    logic                r_ser_out;
    logic                r_ser_valid;
`ifdef SERIAL_MUX_TX_PARITY_EN
    logic                r_par;
`endif

    logic                w_en;
    logic [NUM_CH-1:0]   w_gnt;
    logic [PORT_W-1:0]   w_idx;
    logic                w_any;
    logic [DATA_W-1:0]   w_word;

    // Reset blocks the grant so no source sees a handshake that is discarded.
    assign w_en = (r_state == ST_IDLE) && !rst;

    rr_arbiter4 u_arb (
        .req        (ch_valid),
        .last_grant (r_last),
        .en         (w_en),
        .gnt_onehot (w_gnt),
        .gnt_idx    (w_idx),
        .any_gnt    (w_any)
    );

    always_comb begin
        w_word = ch_data0;
        unique case (w_idx)
            2'd0: w_word = ch_data0;
            2'd1: w_word = ch_data1;
            2'd2: w_word = ch_data2;
            2'd3: w_word = ch_data3;
            default: w_word = ch_data0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_shreg     <= '0;
            r_cnt       <= '0;
            r_last      <= PORT_W'(NUM_CH - 1);
            r_port      <= '0;
            r_ser_out   <= 1'b0;
            r_ser_valid <= 1'b0;
`ifdef SERIAL_MUX_TX_PARITY_EN
            r_par       <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_ser_out   <= 1'b0;
                    r_ser_valid <= 1'b0;
                    if (w_any) begin
                        r_shreg <= w_word;
                        r_port  <= w_idx;
                        r_last  <= w_idx;
                        r_cnt   <= '0;
                        r_state <= ST_SHIFT;
`ifdef SERIAL_MUX_TX_PARITY_EN
                        r_par   <= 1'b0;
`endif
                    end
                end
                ST_SHIFT: begin
                    r_ser_out   <= r_shreg[0];
                    r_ser_valid <= 1'b1;
                    r_shreg     <= r_shreg >> 1;
                    r_cnt       <= r_cnt + CNT_W'(1);
`ifdef SERIAL_MUX_TX_PARITY_EN
                    r_par       <= r_par ^ r_shreg[0];
`endif
                    if (r_cnt == CNT_W'(DATA_W - 1)) begin
`ifdef SERIAL_MUX_TX_PARITY_EN
                        r_state <= ST_PAR;
`else
                        r_state <= ST_IDLE;
`endif
                    end
                end
`ifdef SERIAL_MUX_TX_PARITY_EN
                ST_PAR: begin
                    r_ser_out   <= r_par;
                    r_ser_valid <= 1'b1;
                    r_state     <= ST_IDLE;
                end
`endif
                default: begin
                    r_ser_out   <= 1'b0;
                    r_ser_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign ch_ready  = w_gnt;
    assign ser_out   = r_ser_out;
    assign ser_valid = r_ser_valid;
    assign port_num  = r_port;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_serial_mux_tx.sv
// Randomized bench for serial_mux_tx against a queue-based frame model.
// Parity expectation follows SERIAL_MUX_TX_PARITY_EN.
module tb_serial_mux_tx;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    ch_valid;
    logic [3:0]    ch_ready;
    logic [DW-1:0] d [4];
    logic          ser_out;
    logic          ser_valid;
    logic [1:0]    port_num;
    logic          busy;

    always #5 clk = ~clk;

    serial_mux_tx #(.DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .ch_valid  (ch_valid),
        .ch_ready  (ch_ready),
        .ch_data0  (d[0]),
        .ch_data1  (d[1]),
        .ch_data2  (d[2]),
        .ch_data3  (d[3]),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .port_num  (port_num),
        .busy      (busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Model: a frame is a queue of bits still to appear on the line.
    bit q[$];
    int m_last = 3;
    bit m_ob, m_ov, m_busy;
    int m_port;
    int grants[$];
    int last_g;

    function automatic int pick();
        if (rst || q.size() != 0) return -1;
        for (int k = 1; k <= 4; k++)
            if (ch_valid[(m_last + k) % 4]) return (m_last + k) % 4;
        return -1;
    endfunction

    task automatic cycle();
        int g;
        logic [3:0] er;
        logic [DW-1:0] w;
        bit p;
        @(negedge clk);
        g  = pick();
        er = (g < 0) ? 4'b0 : 4'(1 << g);
        chk("ch_ready", 32'(ch_ready), 32'(er));
        chk("ser_out", 32'(ser_out), 32'(m_ob));
        chk("ser_valid", 32'(ser_valid), 32'(m_ov));
        chk("port_num", 32'(port_num), 32'(m_port));
        chk("busy", 32'(busy), 32'(m_busy));
        @(posedge clk);
        if (rst) begin
            q.delete();
            {m_ob, m_ov, m_busy} = 3'b000;
            m_port = 0;
            m_last = 3;
        end else begin
            if (q.size() > 0) begin
                m_ob = q.pop_front();
                m_ov = 1'b1;
            end else begin
                m_ob = 1'b0;
                m_ov = 1'b0;
            end
            if (g >= 0) begin
                w = d[g];
                p = 1'b0;
                for (int b = 0; b < DW; b++) begin
                    q.push_back(w[b]);
                    p ^= w[b];
                end
`ifdef SERIAL_MUX_TX_PARITY_EN
                q.push_back(p);
`endif
                m_port = g;
                m_last = g;
                grants.push_back(g);
            end
            m_busy = (q.size() > 0);
        end
        last_g = g;
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        rst = 1'b1;
        ch_valid = 4'b0;
        for (int c = 0; c < 4; c++) d[c] = '0;
        @(posedge clk);
        #1;
        cycle();
        rst = 1'b0;

        // Single word on channel 0
        d[0] = 8'hA5;
        ch_valid = 4'b0001;
        cycle();
        ch_valid = 4'b0000;
        run(12);

        // All channels busy: strict rotation from channel 0
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        grants.delete();
        d[0] = 8'h01; d[1] = 8'h02; d[2] = 8'h04; d[3] = 8'h08;
        ch_valid = 4'b1111;
        run(46);
        ch_valid = 4'b0000;
        for (int k = 0; k < 5; k++)
            chk("rr_order", 32'(grants[k]), 32'(k % 4));
        run(12);

        // Late request arriving during channel 1 frame
        grants.delete();
        d[1] = 8'h3C;
        ch_valid = 4'b0010;
        cycle();
        d[2] = 8'hC3;
        ch_valid = 4'b0100;
        run(12);
        ch_valid = 4'b0000;
        chk("late_grant", 32'(grants[grants.size() - 1]), 32'd2);
        run(10);

        // Reset in the middle of a frame
        d[3] = 8'hFF;
        ch_valid = 4'b1000;
        cycle();
        ch_valid = 4'b0000;
        run(4);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        ch_valid = 4'b1111;
        grants.delete();
        cycle();
        ch_valid = 4'b0000;
        chk("post_rst_grant", 32'(grants[0]), 32'd0);
        run(11);

        // Request coinciding with reset
        ch_valid = 4'b0100;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        ch_valid = 4'b0000;
        chk("after_rst_accept", 32'(last_g), 32'd2);
        run(11);

        // Parity-sensitive words
        d[0] = 8'h07;
        ch_valid = 4'b0001;
        cycle();
        ch_valid = 4'b0000;
        run(11);
        d[0] = 8'h03;
        ch_valid = 4'b0001;
        cycle();
        ch_valid = 4'b0000;
        run(11);

        // Random traffic with occasional reset and dropped requests
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int c = 0; c < 4; c++) begin
                if (last_g == c) begin
                    ch_valid[c] = ($urandom_range(0, 1) == 1);
                    d[c] = DW'($urandom);
                end else if (!ch_valid[c]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        ch_valid[c] = 1'b1;
                        d[c] = DW'($urandom);
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    ch_valid[c] = 1'b0;
                end
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_mux_tx.md
Name: serial_mux_tx

Overview:
- Transmit-side counterpart of the 1-to-4 serial demultiplexer.
- Accepts parallel words from four channels and arbitrates among them round-robin.
- Serializes one word per frame onto ser_out, LSB first.
- Drives port_num, held stable for the whole frame, so the receiving demux routes every bit of the frame to the same output.

Parameters:
- DATA_W, 8, width of each channel word and number of data bits per frame (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- ch_valid  input  4  bit i: channel i has a word to send.
- ch_ready  output  4  bit i: channel i word accepted this cycle (one-hot or zero).
- ch_data0  input  DATA_W  channel 0 word.
- ch_data1  input  DATA_W  channel 1 word.
- ch_data2  input  DATA_W  channel 2 word.
- ch_data3  input  DATA_W  channel 3 word.
- ser_out  output  1  serial data, registered.
- ser_valid  output  1  high while ser_out carries a frame bit, registered.
- port_num  output  2  destination channel of the current frame, registered.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, clk; rst is synchronous and active-high. On rst at a clk edge:
  - state=IDLE, ser_out=0, ser_valid=0, port_num=0, busy=0.
  - bit counter=0; last_grant=3, so channel 0 has first priority.
  - ch_ready=0 in the reset cycle.
- States: IDLE, SHIFT (plus PAR when the optional feature is enabled).
- IDLE:
  - Round-robin search over ch_valid, starting at last_grant+1 mod 4.
  - If any channel i is valid: ch_ready[i]=1 combinationally in this cycle; the transfer completes on this edge.
  - On that edge: shift register <= ch_data_i; port_num <= i; last_grant <= i; counter <= 0; state <= SHIFT.
  - ser_out=0 and ser_valid=0 in IDLE.
- SHIFT:
  - Each cycle: ser_out <= shreg[0]; ser_valid <= 1; shreg shifts right; counter increments.
  - After the bit at counter=DATA_W-1 has been registered: next state is IDLE (or PAR).
- Latency: acceptance at edge N; bit 0 is visible on ser_out in the cycle after edge N+1. The last data bit is visible DATA_W-1 cycles later.
- Inter-frame gap: ser_valid is low for at least one cycle between frames.
  - Frame period with continuous demand = DATA_W+1 cycles, or DATA_W+2 with parity.
- port_num:
  - Changes only at acceptance edges.
  - Constant while ser_valid=1.
  - Retains the last value while idle.
- ch_ready:
  - Never asserted outside IDLE.
  - Never asserted to a channel whose ch_valid is low.
  - At most one bit set.
- ch_valid may drop without being served (no hold requirement on sources). Once asserted, ch_data must remain stable until ch_ready.
- Fairness: with all four channels continuously valid, grants cycle 0,1,2,3,0,…
  - A channel waits at most 3 frames.
- Reset mid-frame: the frame is aborted. ser_valid=0 after that edge; the partial word is lost and not retransmitted.
- rst has priority over all other events, including an acceptance in the same cycle.

Optional Feature:
- Macro SERIAL_MUX_TX_PARITY_EN.
- Defined:
  - After the last data bit, state PAR emits one even-parity bit (XOR of the DATA_W data bits) with ser_valid=1.
  - Then IDLE.
- Undefined:
  - No PAR state; SHIFT goes directly to IDLE.
  - Frame is DATA_W bits.

Decomposition:
- Package serial_mux_pkg:
  - NUM_CH=4, PORT_W=2.
  - State enum type (IDLE, SHIFT, PAR).
- Sub-module rr_arbiter4:
  - Inputs: req[3:0], last_grant[1:0], en.
  - Outputs: gnt_onehot[3:0], gnt_idx[1:0], any_gnt.
  - Purely combinational.
- Shift register, counter and FSM stay in serial_mux_tx.

Test Plan:
- Reset then ch_valid=0001, ch_data0=8'hA5:
  - ch_ready=0001 for exactly one cycle; port_num=0.
  - ser_out=1,0,1,0,0,1,0,1 over 8 consecutive ser_valid cycles; ser_valid then low.
- All ch_valid=1111 held, with data 8'h01, 8'h02, 8'h04, 8'h08:
  - Grants in order 0,1,2,3,0.
  - Each frame is 8 bits with a 1-cycle gap.
  - port_num is stable within each frame.
- ch_valid=0100 asserted while channel 1's frame is in SHIFT:
  - No ch_ready until the first IDLE cycle, then ch_ready=0100 and port_num=2.
- rst pulsed at the 4th bit of a frame:
  - Next cycle: ser_valid=0, ser_out=0, port_num=0, busy=0.
  - With ch_valid=1111, the next grant goes to channel 0.
- ch_valid asserted and rst=1 in the same cycle:
  - No ch_ready, state stays IDLE.
  - Acceptance occurs in the first cycle after rst deasserts.
- With SERIAL_MUX_TX_PARITY_EN defined, data 8'h07:
  - 9 ser_valid cycles; 9th bit = 1.
  - With 8'h03, 9th bit = 0.
